fft_input_buffer: RTL and testbench

Upstream neighbour of the FFT output buffer. Captures one frame of 256 serial signed 20-bit samples and stores each in bit-reversed address order as a 30-bit fixed-point word (10 fractional bits). Once the frame is full it signals the butterfly FSM. The FSM then reads eight words per cycle by address until it releases the buffer. The 30-bit word format matches the one the output buffer truncates back to 20 bits (`[29:10]`).

---
 rtl/fft_input_buffer.sv | 213 +++++++++++++++++++++
 tb/tb_fft_input_buffer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_input_buffer.sv
// ----------------------------------------------------------------------------
// fft_input_buffer
//
// Captures one frame of N_POINTS serial signed samples and stores each one,
// widened to DATA_W bits with FRAC_BITS zero fraction bits, at the
// bit-reversed address of its sample index. When the frame is complete it
// pulses startfft and holds the frame read-only until the butterfly FSM
// releases it. While full, eight words can be read per cycle.
//
// Strobe protocol: there is no back-pressure on any interface. startin is a
// one-cycle request that is accepted only in IDLE, or in FULL together with
// release_i; a startin seen anywhere else is dropped and recorded in the
// sticky overrun flag. read is honoured only in FULL; otherwise the read
// registers hold their last value.
//
// Ports:
//   clock, reset             rising-edge clock, synchronous active-high reset
//   startin, in              frame start pulse and serial sample stream
//   read, addr0..addr7       read strobe and eight read addresses
//   release_i                FSM is done with the frame ("release" is a
//                            reserved word, hence the suffix)
//   data_out_0..data_out_7   registered read data, 1-cycle latency
//   startfft                 one-cycle pulse in the first FULL cycle
//   busy                     state is not IDLE
//   overrun                  sticky: a startin was dropped
//   dbg_state                current FSM state (0 IDLE, 1 LOAD, 2 FULL)
// ----------------------------------------------------------------------------
module fft_input_buffer #(
    parameter int N_POINTS  = 256,
    parameter int IN_W      = 20,
    parameter int FRAC_BITS = 10,
    parameter int DATA_W    = IN_W + FRAC_BITS,
    localparam int ADDR_W   = $clog2(N_POINTS)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     startin,
    input  logic signed [IN_W-1:0]   in,
    input  logic                     read,
    input  logic [ADDR_W-1:0]        addr0,
    input  logic [ADDR_W-1:0]        addr1,
    input  logic [ADDR_W-1:0]        addr2,
    input  logic [ADDR_W-1:0]        addr3,
    input  logic [ADDR_W-1:0]        addr4,
    input  logic [ADDR_W-1:0]        addr5,
    input  logic [ADDR_W-1:0]        addr6,
    input  logic [ADDR_W-1:0]        addr7,
    input  logic                     release_i,
    output logic signed [DATA_W-1:0] data_out_0,
    output logic signed [DATA_W-1:0] data_out_1,
    output logic signed [DATA_W-1:0] data_out_2,
    output logic signed [DATA_W-1:0] data_out_3,
    output logic signed [DATA_W-1:0] data_out_4,
    output logic signed [DATA_W-1:0] data_out_5,
    output logic signed [DATA_W-1:0] data_out_6,
    output logic signed [DATA_W-1:0] data_out_7,
    output logic                     startfft,
    output logic                     busy,
    output logic                     overrun,
    output logic [1:0]               dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(N_POINTS - 1);

    function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        for (int i = 0; i < ADDR_W; i++) begin
            r[i] = a[ADDR_W-1-i];
        end
        return r;
    endfunction

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   count_q, count_d;
    logic                overrun_q, overrun_d;
    logic                startfft_q, startfft_d;
    logic [DATA_W-1:0]   dout_q [8];
    logic [DATA_W-1:0]   mem [N_POINTS];
    logic [ADDR_W-1:0]   raddr [8];

    logic                we;
    logic [ADDR_W-1:0]   waddr;
    logic [DATA_W-1:0]   wdata;
    logic                rd_en;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            overrun_q  <= 1'b0;
            startfft_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            overrun_q  <= overrun_d;
            startfft_q <= startfft_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        overrun_d  = overrun_q;
        // Registered so the pulse lands in the first FULL cycle.
        startfft_d = (state_q == LOAD) && (count_q == LAST_CNT);
        case (state_q)
            IDLE: begin
                if (startin) begin
                    state_d = LOAD;
                    count_d = ADDR_W'(1);
                end
            end
            LOAD: begin
                // Wraps to 0 on the last sample, leaving count clean in FULL.
                count_d = count_q + ADDR_W'(1);
                if (startin) overrun_d = 1'b1;
                if (count_q == LAST_CNT) state_d = FULL;
            end
            FULL: begin
                if (release_i) begin
                    if (startin) begin
                        state_d = LOAD;
                        count_d = ADDR_W'(1);
                    end else begin
                        state_d = IDLE;
                        count_d = '0;
                    end
                end else if (startin) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath control
    // ------------------------------------------------------------------
    always_comb begin
        we    = 1'b0;
        waddr = '0;
        rd_en = 1'b0;
        case (state_q)
            IDLE: we = startin;
            LOAD: begin
                we    = 1'b1;
                waddr = bitrev(count_q);
            end
            FULL: begin
                // Sample 0 always lands at address 0 (bitrev of 0).
                we    = release_i && startin;
                rd_en = read;
            end
            default: ;
        endcase
    end

    assign wdata = {in, {FRAC_BITS{1'b0}}};

    // Storage is deliberately not reset.
    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    assign raddr[0] = addr0;
    assign raddr[1] = addr1;
    assign raddr[2] = addr2;
    assign raddr[3] = addr3;
    assign raddr[4] = addr4;
    assign raddr[5] = addr5;
    assign raddr[6] = addr6;
    assign raddr[7] = addr7;

    // A write to address 0 in the same cycle as a read returns the old
    // frame's word, since the read samples mem before the edge updates it.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < 8; k++) dout_q[k] <= '0;
        end else if (rd_en) begin
            for (int k = 0; k < 8; k++) dout_q[k] <= mem[raddr[k]];
        end
    end

    assign data_out_0 = dout_q[0];
    assign data_out_1 = dout_q[1];
    assign data_out_2 = dout_q[2];
    assign data_out_3 = dout_q[3];
    assign data_out_4 = dout_q[4];
    assign data_out_5 = dout_q[5];
    assign data_out_6 = dout_q[6];
    assign data_out_7 = dout_q[7];

    assign startfft  = startfft_q;
    assign busy      = (state_q != IDLE);
    assign overrun   = overrun_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fft_input_buffer.sv
module tb_fft_input_buffer;
    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               startin = 1'b0;
    logic signed [19:0] in = '0;
    logic               read = 1'b0;
    logic               release_i = 1'b0;
    logic [7:0]         rd_addr [8];
    logic signed [29:0] data_out_0, data_out_1, data_out_2, data_out_3;
    logic signed [29:0] data_out_4, data_out_5, data_out_6, data_out_7;
    logic               startfft, busy, overrun;
    logic [1:0]         dbg_state;

    logic [29:0] model_mem [256];
    logic [29:0] held [8];
    logic [29:0] exp_q [$];
    int          errors = 0;
    int          checks = 0;
    int          ramp_exp [8] = '{0, 128, 64, 192, 1, 3, 127, 255};

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    fft_input_buffer dut (
        .clock(clock), .reset(reset), .startin(startin), .in(in), .read(read),
        .addr0(rd_addr[0]), .addr1(rd_addr[1]), .addr2(rd_addr[2]), .addr3(rd_addr[3]),
        .addr4(rd_addr[4]), .addr5(rd_addr[5]), .addr6(rd_addr[6]), .addr7(rd_addr[7]),
        .release_i(release_i),
        .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2),
        .data_out_3(data_out_3), .data_out_4(data_out_4), .data_out_5(data_out_5),
        .data_out_6(data_out_6), .data_out_7(data_out_7),
        .startfft(startfft), .busy(busy), .overrun(overrun), .dbg_state(dbg_state)
    );

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] a);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = a[7-i];
        return r;
    endfunction

    function automatic logic [19:0] sample(input int kind, input int k);
        if (kind == 0) return 20'(k);
        if (kind == 1 && k == 0) return 20'hFFFFF;
        if (kind == 1 && k == 1) return 20'h7FFFF;
        return 20'($urandom_range(0, 32'hFFFFF));
    endfunction

    function automatic logic [29:0] get_out(input int k);
        case (k)
            0: return data_out_0;
            1: return data_out_1;
            2: return data_out_2;
            3: return data_out_3;
            4: return data_out_4;
            5: return data_out_5;
            6: return data_out_6;
            7: return data_out_7;
            default: return '0;
        endcase
    endfunction

    task automatic random_addrs();
        for (int j = 0; j < 8; j++) rd_addr[j] = 8'($urandom_range(0, 255));
    endtask

    task automatic check_cleared(input string tag);
        for (int j = 0; j < 8; j++) check($sformatf("%s_dout%0d", tag, j), 32'(get_out(j)), 0);
        check({tag, "_startfft"}, 32'(startfft), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_overrun"}, 32'(overrun), 0);
        check({tag, "_state"}, 32'(dbg_state), 0);
    endtask

    // One read strobe; live=1 expects memory words, live=0 expects a hold.
    task automatic read_frame(input bit live);
        logic [29:0] e;
        for (int j = 0; j < 8; j++) begin
            e = live ? model_mem[rd_addr[j]] : held[j];
            exp_q.push_back(e);
            held[j] = e;
        end
        read = 1'b1;
        tick();
        read = 1'b0;
        for (int j = 0; j < 8; j++)
            check($sformatf("data_out_%0d", j), 32'(get_out(j)), 32'(exp_q.pop_front()));
    endtask

    // Drives one frame from sample 0 (cycle T) to sample 255 (cycle T+255).
    // rel_first: release in cycle T (previous frame still FULL).
    // ovr_at: extra startin at that sample index; read_at: read strobe there.
    task automatic load_frame(input int kind, input int ovr_at, input bit rel_first,
                              input int read_at);
        logic [19:0] s;
        logic [29:0] e;
        for (int k = 0; k < 256; k++) begin
            s         = sample(kind, k);
            startin   = (k == 0) || (k == ovr_at);
            in        = s;
            release_i = rel_first && (k == 0);
            read      = (k == read_at);
            if (k == read_at) begin
                for (int j = 0; j < 8; j++) begin
                    e = (k == 0 && rel_first) ? model_mem[rd_addr[j]] : held[j];
                    exp_q.push_back(e);
                    held[j] = e;
                end
            end
            model_mem[rev8(8'(k))] = {s, 10'b0};
            tick();
            read = 1'b0;
            if (k == read_at) begin
                for (int j = 0; j < 8; j++)
                    check($sformatf("frame_read_%0d", j), 32'(get_out(j)), 32'(exp_q.pop_front()));
            end
            if (k < 255) check("startfft_low", 32'(startfft), 0);
            else         check("startfft_pulse", 32'(startfft), 1);
            check("busy_frame", 32'(busy), 1);
        end
        check("state_full", 32'(dbg_state), 2);
        startin   = 1'b0;
        release_i = 1'b0;
    endtask

    task automatic release_to_idle();
        release_i = 1'b1;
        tick();
        release_i = 1'b0;
        check("busy_after_release", 32'(busy), 0);
        check("state_idle", 32'(dbg_state), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int j = 0; j < 8; j++) begin
            rd_addr[j] = '0;
            held[j]    = '0;
        end

        tick(); tick(); tick();
        check_cleared("reset");
        reset = 1'b0;
        tick();

        // Ramp frame, read in cycle T+256.
        load_frame(0, -1, 0, -1);
        rd_addr = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd128, 8'd192, 8'd254, 8'd255};
        read_frame(1'b1);
        for (int j = 0; j < 8; j++)
            check($sformatf("ramp_%0d", j), 32'(get_out(j)), 32'(ramp_exp[j] << 10));
        check("ramp_overrun", 32'(overrun), 0);

        // Sign and scaling frame.
        load_frame(1, -1, 1'b1, -1);
        rd_addr = '{8'd0, 8'd128, 8'd0, 8'd128, 8'd64, 8'd192, 8'd1, 8'd255};
        read_frame(1'b1);
        check("sign_s0", 32'(get_out(0)), 32'h3FFF_FC00);
        check("sign_s1", 32'(get_out(1)), 32'h1FFF_FC00);

        // Back-to-back: frame A, then frame B started in A's T+256 with
        // release and a read of frame A in that same cycle.
        load_frame(2, -1, 1'b1, -1);
        random_addrs();
        rd_addr[0] = 8'd0;
        load_frame(2, -1, 1'b1, 0);
        check("b2b_overrun", 32'(overrun), 0);
        random_addrs();
        read_frame(1'b1);

        // Read gating in IDLE.
        release_to_idle();
        random_addrs();
        read_frame(1'b0);

        // Overrun during LOAD plus read gating during LOAD.
        random_addrs();
        load_frame(2, 100, 1'b0, 60);
        check("overrun_load", 32'(overrun), 1);
        random_addrs();
        read_frame(1'b1);

        // startin in FULL without release: ignored, frame held.
        startin = 1'b1;
        in      = 20'h12345;
        tick();
        startin = 1'b0;
        check("overrun_full", 32'(overrun), 1);
        check("full_held_state", 32'(dbg_state), 2);
        check("full_held_busy", 32'(busy), 1);
        check("full_held_startfft", 32'(startfft), 0);
        random_addrs();
        rd_addr[0] = 8'd0;
        read_frame(1'b1);

        // Reset mid-LOAD at T+50.
        release_to_idle();
        startin = 1'b1;
        in      = 20'h0ABCD;
        tick();
        startin = 1'b0;
        for (int k = 1; k < 50; k++) begin
            in = 20'($urandom_range(0, 32'hFFFFF));
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int j = 0; j < 8; j++) held[j] = '0;
        check_cleared("mid_reset");

        load_frame(2, -1, 1'b0, -1);
        check("post_reset_overrun", 32'(overrun), 0);
        random_addrs();
        read_frame(1'b1);

        check("exp_q_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
